pcm_i2s_tx: RTL and testbench

Serialises the synth voice's 16-bit PCM output (the post-filter sample stream) into an I2S frame for the external audio codec. Accepts one mono sample per frame over a valid/ready handshake and drives it, MSB-first, into both left and right slots. Generates BCLK and LRCLK from the system clock. Sits between the filter/mixer output and the board-level codec pins.

---
 rtl/synth_audio_pkg.sv | 18 +
 rtl/bclk_gen.sv | 55 +++++
 rtl/pcm_i2s_tx.sv | 149 ++++++++++++++
 tb/tb_pcm_i2s_tx.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_audio_pkg.sv
// Shared definitions for the synth audio output path (I2S transmitter now,
// codec/DAC blocks later).
//   SLOTS_PER_FRAME : BCLK periods per stereo frame
//   SLOT_MSB_LEFT   : slot carrying the left-channel MSB
//   SLOT_MSB_RIGHT  : slot carrying the right-channel MSB
//   i2s_state_t     : frame generator state
package synth_audio_pkg;

    localparam int SLOTS_PER_FRAME = 64;
    localparam int SLOT_MSB_LEFT   = 1;
    localparam int SLOT_MSB_RIGHT  = 33;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_t;

endpackage

// File: rtl/bclk_gen.sv
// BCLK divider for the I2S transmitter.
//   clk_i       : system clock
//   rst_ni      : asynchronous active-low reset
//   start_i     : synchronous clear at IDLE->RUN
//   run_i       : divider runs while high, held cleared otherwise
//   bclk_o      : bit clock, toggles every CLK_DIV clk cycles
//   bclk_fall_o : high in the cycle whose closing edge takes bclk 1->0
module bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic run_i,
    output logic bclk_o,
    output logic bclk_fall_o
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          div_wrap;

    assign div_wrap = run_i && !start_i && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        if (start_i || !run_i) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
        end else if (div_wrap) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o      = bclk_q;
    assign bclk_fall_o = div_wrap && bclk_q;

endmodule

// File: rtl/pcm_i2s_tx.sv
// Mono PCM to I2S serialiser: one sample per frame, sent MSB-first into both
// the left and right slots, one BCLK after each LRCLK edge.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   enable       : run request, honoured at frame boundaries
//   sample_in    : PCM sample, captured on accept
//   sample_valid : sample_in valid
//   sample_ready : holding register empty
//   bclk/lrclk/sdata : I2S pins (lrclk 0 = left)
//   busy         : frame generator running
//   underrun     : sticky, a frame started without a fresh sample
module pcm_i2s_tx #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 bclk,
    output logic                 lrclk,
    output logic                 sdata,
    output logic                 busy,
    output logic                 underrun
);

    import synth_audio_pkg::*;

    localparam logic [5:0] SLOT_LAST = 6'(SLOTS_PER_FRAME - 1);

    i2s_state_t           state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] frame_q, frame_d;
    logic                 hold_full_q, hold_full_d;
    logic [5:0]           slot_q, slot_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 underrun_q, underrun_d;

    logic       start, bclk_fall, accept, boundary, transfer, data_bit;
    logic [5:0] slot_nxt;
    logic [4:0] half_pos;

    bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
        .clk_i       (clk),
        .rst_ni      (reset),
        .start_i     (start),
        .run_i       (state_q == RUN),
        .bclk_o      (bclk),
        .bclk_fall_o (bclk_fall)
    );

    assign accept   = sample_valid && !hold_full_q;
    assign start    = (state_q == IDLE) && enable && hold_full_q;
    assign boundary = (state_q == RUN) && bclk_fall && (slot_q == SLOT_LAST);
    // accept needs an empty hold and transfer a full one, so they never collide
    assign transfer = start || (boundary && enable && hold_full_q);

    // lrclk/sdata are registered on the fall, so they are computed for the
    // slot being entered, not the one being left
    assign slot_nxt = slot_q + 6'd1;
    assign half_pos = slot_nxt[4:0];

    always_comb begin
        data_bit = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (half_pos == 5'(SLOT_MSB_LEFT + DATA_BITS - 1 - i))
                data_bit = frame_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        frame_d     = frame_q;
        slot_d      = slot_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        underrun_d  = underrun_q;

        if (accept) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end
        if (transfer) begin
            frame_d     = hold_q;
            hold_full_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    slot_d  = '0;
                    lrclk_d = 1'b0;
                    sdata_d = 1'b0;
                end
            end
            RUN: begin
                if (boundary) begin
                    slot_d  = '0;
                    lrclk_d = 1'b0;
                    sdata_d = 1'b0;
                    if (!enable)
                        state_d = IDLE;
                    else if (!hold_full_q)
                        underrun_d = 1'b1;   // frame_q repeats
                end else if (bclk_fall) begin
                    slot_d  = slot_nxt;
                    lrclk_d = slot_nxt[5];
                    sdata_d = data_bit;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            frame_q     <= '0;
            slot_q      <= '0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            frame_q     <= frame_d;
            slot_q      <= slot_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign busy         = (state_q == RUN);
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx: dut0 at CLK_DIV=2, dut1 at CLK_DIV=1. A codec-style
// receiver samples lrclk/sdata on every bclk rise and rebuilds the words.
module tb_pcm_i2s_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  en, sval, rdy, bc, lr, sd, busy, ur;
    logic [15:0] sin0, sin1;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    pcm_i2s_tx #(.CLK_DIV(2), .DATA_BITS(16)) dut0 (
        .clk(clk), .reset(rst_n), .enable(en[0]), .sample_in(sin0),
        .sample_valid(sval[0]), .sample_ready(rdy[0]), .bclk(bc[0]),
        .lrclk(lr[0]), .sdata(sd[0]), .busy(busy[0]), .underrun(ur[0]));

    pcm_i2s_tx #(.CLK_DIV(1), .DATA_BITS(16)) dut1 (
        .clk(clk), .reset(rst_n), .enable(en[1]), .sample_in(sin1),
        .sample_valid(sval[1]), .sample_ready(rdy[1]), .bclk(bc[1]),
        .lrclk(lr[1]), .sdata(sd[1]), .busy(busy[1]), .underrun(ur[1]));

    // ---------------- receiver model ----------------
    logic [1:0]  pb, plr, psd, lastlr;
    int          pos [2];
    logic [15:0] wd [2];
    int          pad_err [2]   = '{0, 0};
    int          algn_err [2]  = '{0, 0};
    int          per_err [2]   = '{0, 0};
    int          last_rise [2];
    logic [15:0] rxq0 [$];
    logic [15:0] rxq1 [$];
    int          lrr0 [$];
    int          lrr1 [$];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin : rx_lane
            int          np;
            logic [15:0] nw;
            if (busy[k] === 1'b1) begin
                // lrclk/sdata may only move together with a bclk fall
                if ((lr[k] !== plr[k] || sd[k] !== psd[k]) && !(pb[k] && !bc[k]))
                    algn_err[k] <= algn_err[k] + 1;
                if (lr[k] && !plr[k]) begin
                    if (k == 0) lrr0.push_back(cyc); else lrr1.push_back(cyc);
                end
                if (bc[k] && !pb[k]) begin
                    if (last_rise[k] >= 0 && (cyc - last_rise[k]) != 4 - 2 * k)
                        per_err[k] <= per_err[k] + 1;
                    last_rise[k] <= cyc;
                    np = (lr[k] !== lastlr[k]) ? 0 : pos[k] + 1;
                    pos[k] <= np;
                    lastlr[k] <= lr[k];
                    if (np >= 1 && np <= 16) begin
                        nw = {wd[k][14:0], sd[k]};
                        wd[k] <= nw;
                        if (np == 16) begin
                            if (k == 0) rxq0.push_back(nw); else rxq1.push_back(nw);
                        end
                    end else if (sd[k]) begin
                        pad_err[k] <= pad_err[k] + 1;
                    end
                end
            end else begin
                pos[k]       <= -1;
                lastlr[k]    <= 1'b0;
                last_rise[k] <= -1;
            end
            pb[k]  <= bc[k];
            plr[k] <= lr[k];
            psd[k] <= sd[k];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 2'b00; sval = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input int k, input logic [15:0] v);
        bit done = 0;
        for (int i = 0; i < 700 && !done; i++) begin
            @(negedge clk);
            if (rdy[k]) begin
                if (k == 0) sin0 = v; else sin1 = v;
                sval[k] = 1'b1;
                @(negedge clk);
                sval[k] = 1'b0;
                if (k == 0) sin0 = 16'($urandom); else sin1 = 16'($urandom);
                done = 1;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL send_accept k=%0d got=no_ready exp=ready", k); end
    endtask

    task automatic wait_words(input int k, input int n);
        int i = 0;
        while (((k == 0) ? rxq0.size() : rxq1.size()) < n && i < 3000) begin
            @(negedge clk); i++;
        end
        if (i >= 3000) begin
            checks++; errors++;
            $display("FAIL wait_words k=%0d got=timeout exp=%0d words", k, n);
        end
    endtask

    task automatic wait_idle(input int k);
        int i = 0;
        while (busy[k] !== 1'b0 && i < 1000) begin @(negedge clk); i++; end
        if (i >= 1000) begin
            checks++; errors++;
            $display("FAIL wait_idle k=%0d got=busy exp=idle", k);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int b, i;
        bit saw_busy;
        rst_n = 1'b0; en = 2'b00; sval = 2'b00; sin0 = '0; sin1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bc[0], lr[0], sd[0], busy[0], ur[0], rdy[0]} !== 6'b000001) begin
            errors++; $display("FAIL reset_values got=%b exp=000001",
                               {bc[0], lr[0], sd[0], busy[0], ur[0], rdy[0]});
        end
        rst_n = 1'b1;
        @(negedge clk);
        b = rxq0.size();
        en[0] = 1'b1;
        send(0, 16'h1357);
        wait_words(0, b + 2);
        checks++;
        if (rxq0[b] !== 16'h1357) begin errors++; $display("FAIL reset_pre_word got=%h exp=1357", rxq0[b]); end
        // slot 20 of the second (repeated) frame
        i = 0;
        while (!(pos[0] == 20 && lr[0] == 1'b0) && i < 2000) begin @(negedge clk); i++; end
        checks++;
        if (i >= 2000) begin errors++; $display("FAIL reset_slot20 got=timeout exp=slot20"); end
        checks++;
        if (ur[0] !== 1'b1) begin errors++; $display("FAIL reset_pre_underrun got=%b exp=1", ur[0]); end
        send(0, 16'h2468);
        checks++;
        if (rdy[0] !== 1'b0) begin errors++; $display("FAIL reset_pre_ready got=%b exp=0", rdy[0]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bc[0], lr[0], sd[0], busy[0], ur[0], rdy[0]} !== 6'b000001) begin
            errors++; $display("FAIL reset_async got=%b exp=000001",
                               {bc[0], lr[0], sd[0], busy[0], ur[0], rdy[0]});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        saw_busy = 0;
        repeat (60) begin @(negedge clk); if (busy[0] !== 1'b0) saw_busy = 1; end
        checks++;
        if (saw_busy || {bc[0], lr[0], sd[0], busy[0], ur[0], rdy[0]} !== 6'b000001) begin
            errors++; $display("FAIL reset_stay_idle got=%b busy_seen=%0d exp=000001",
                               {bc[0], lr[0], sd[0], busy[0], ur[0], rdy[0]}, saw_busy);
        end
        en[0] = 1'b0;
    endtask

    task automatic test_single_frame();
        int b, bl, pe, ae, pd, t0, i;
        do_reset();
        b = rxq0.size(); bl = lrr0.size();
        pe = per_err[0]; ae = algn_err[0]; pd = pad_err[0];
        en[0] = 1'b1;
        send(0, 16'hA5C3);
        i = 0;
        while (busy[0] !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        t0 = cyc;
        i = 0;
        while (bc[0] !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        checks++;
        if (cyc - t0 != 2) begin errors++; $display("FAIL single_first_rise got=%0d exp=2", cyc - t0); end
        wait_words(0, b + 2);
        checks++;
        if (rxq0[b] !== 16'hA5C3) begin errors++; $display("FAIL single_left got=%h exp=a5c3", rxq0[b]); end
        checks++;
        if (rxq0[b+1] !== 16'hA5C3) begin errors++; $display("FAIL single_right got=%h exp=a5c3", rxq0[b+1]); end
        i = 0;
        while (lrr0.size() < bl + 2 && i < 1000) begin @(negedge clk); i++; end
        checks++;
        if (lrr0[bl+1] - lrr0[bl] != 256) begin
            errors++; $display("FAIL single_frame_len got=%0d exp=256", lrr0[bl+1] - lrr0[bl]);
        end
        checks++;
        if (per_err[0] != pe || algn_err[0] != ae || pad_err[0] != pd) begin
            errors++; $display("FAIL single_timing got=per%0d/algn%0d/pad%0d exp=0/0/0",
                               per_err[0] - pe, algn_err[0] - ae, pad_err[0] - pd);
        end
        en[0] = 1'b0;
        wait_idle(0);
    endtask

    task automatic test_stream();
        int b;
        logic [15:0] s [11];
        do_reset();
        b = rxq0.size();
        for (int i = 0; i < 11; i++) s[i] = 16'($urandom);
        en[0] = 1'b1;
        for (int i = 0; i < 11; i++) send(0, s[i]);
        wait_words(0, b + 20);
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (rxq0[b+2*j] !== s[j]) begin
                errors++; $display("FAIL stream_left f=%0d got=%h exp=%h", j, rxq0[b+2*j], s[j]);
            end
            checks++;
            if (rxq0[b+2*j+1] !== s[j]) begin
                errors++; $display("FAIL stream_right f=%0d got=%h exp=%h", j, rxq0[b+2*j+1], s[j]);
            end
        end
        checks++;
        if (ur[0] !== 1'b0) begin errors++; $display("FAIL stream_underrun got=%b exp=0", ur[0]); end
        en[0] = 1'b0;
        wait_idle(0);
    endtask

    task automatic test_underrun();
        int b;
        logic [15:0] exp_w [8];
        exp_w = '{16'h1234, 16'h1234, 16'h7FFF, 16'h7FFF,
                  16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        do_reset();
        b = rxq0.size();
        en[0] = 1'b1;
        send(0, 16'h1234);
        send(0, 16'h7FFF);
        wait_words(0, b + 4);
        checks++;
        if (ur[0] !== 1'b0) begin errors++; $display("FAIL underrun_early got=%b exp=0", ur[0]); end
        wait_words(0, b + 6);
        checks++;
        if (ur[0] !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b exp=1", ur[0]); end
        send(0, 16'h8000);
        wait_words(0, b + 8);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (rxq0[b+j] !== exp_w[j]) begin
                errors++; $display("FAIL underrun_word w=%0d got=%h exp=%h", j, rxq0[b+j], exp_w[j]);
            end
        end
        checks++;
        if (ur[0] !== 1'b1) begin errors++; $display("FAIL underrun_sticky got=%b exp=1", ur[0]); end
        en[0] = 1'b0;
        wait_idle(0);
    endtask

    task automatic test_stop();
        int b, t;
        bit saw_busy;
        do_reset();
        b = rxq0.size();
        en[0] = 1'b1;
        send(0, 16'h1111);
        send(0, 16'h2222);
        wait_words(0, b + 1);
        en[0] = 1'b0;
        wait_idle(0);
        t = cyc;
        checks++;
        if (t - lrr0[lrr0.size()-1] != 128) begin
            errors++; $display("FAIL stop_at_slot63 got=%0d exp=128", t - lrr0[lrr0.size()-1]);
        end
        checks++;
        if ({bc[0], lr[0], sd[0]} !== 3'b000) begin
            errors++; $display("FAIL stop_pins got=%b exp=000", {bc[0], lr[0], sd[0]});
        end
        checks++;
        if (rxq0.size() != b + 2 || rxq0[b+1] !== 16'h1111) begin
            errors++; $display("FAIL stop_frame got=%0d words/%h exp=2 words/1111", rxq0.size() - b, rxq0[b+1]);
        end
        checks++;
        if (rdy[0] !== 1'b0 || ur[0] !== 1'b0) begin
            errors++; $display("FAIL stop_hold got=rdy%b/ur%b exp=rdy0/ur0", rdy[0], ur[0]);
        end
        saw_busy = 0;
        repeat (300) begin @(negedge clk); if (busy[0] !== 1'b0) saw_busy = 1; end
        checks++;
        if (saw_busy) begin errors++; $display("FAIL stop_stays_idle got=busy exp=idle"); end
        en[0] = 1'b1;
        wait_words(0, b + 4);
        checks++;
        if (rxq0[b+2] !== 16'h2222 || rxq0[b+3] !== 16'h2222) begin
            errors++; $display("FAIL stop_resume got=%h/%h exp=2222/2222", rxq0[b+2], rxq0[b+3]);
        end
        en[0] = 1'b0;
        wait_idle(0);
    endtask

    task automatic test_clkdiv1();
        int b, bl, pe, ae, pd, t0, i;
        do_reset();
        b = rxq1.size(); bl = lrr1.size();
        pe = per_err[1]; ae = algn_err[1]; pd = pad_err[1];
        en[1] = 1'b1;
        send(1, 16'hC0DE);
        i = 0;
        while (busy[1] !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        t0 = cyc;
        i = 0;
        while (bc[1] !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        checks++;
        if (cyc - t0 != 1) begin errors++; $display("FAIL div1_first_rise got=%0d exp=1", cyc - t0); end
        wait_words(1, b + 4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rxq1[b+j] !== 16'hC0DE) begin
                errors++; $display("FAIL div1_word w=%0d got=%h exp=c0de", j, rxq1[b+j]);
            end
        end
        i = 0;
        while (lrr1.size() < bl + 2 && i < 500) begin @(negedge clk); i++; end
        checks++;
        if (lrr1[bl+1] - lrr1[bl] != 128) begin
            errors++; $display("FAIL div1_frame_len got=%0d exp=128", lrr1[bl+1] - lrr1[bl]);
        end
        checks++;
        if (per_err[1] != pe || algn_err[1] != ae || pad_err[1] != pd) begin
            errors++; $display("FAIL div1_timing got=per%0d/algn%0d/pad%0d exp=0/0/0",
                               per_err[1] - pe, algn_err[1] - ae, pad_err[1] - pd);
        end
        checks++;
        if (ur[1] !== 1'b1) begin errors++; $display("FAIL div1_underrun got=%b exp=1", ur[1]); end
        en[1] = 1'b0;
        wait_idle(1);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stream();
        test_underrun();
        test_stop();
        test_clkdiv1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
